// File: rtl/seg7_pkg.sv
// Shared types and segment patterns for the 7-segment scan driver.
// Patterns are active-high {g,f,e,d,c,b,a}; the driver inverts them for the common-anode pins.
package seg7_pkg;

  typedef enum logic [1:0] {
    OFF,
    DRIVE,
    GUARD
  } scan_state_t;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  // Active-low "everything off" pattern
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-low segment pattern.
// Invalid codes (10-15) and blanked digits light no segments.
module bcd_to_seg7 (
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg_n
);
  import seg7_pkg::*;

  logic [6:0] pattern;

  always_comb begin
    pattern = 7'h00;
    case (bcd)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = 7'h00;
    endcase
    seg_n = blank ? SEG_BLANK : ~pattern;
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with shadow register,
// guard interval between digits and leading-zero blanking.
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 2,
  parameter int BLANK_LZ     = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    scan_tick
);
  import seg7_pkg::*;

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);
  localparam logic [IW-1:0] INDEX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = '1;

  scan_state_t             state_reg, state_next;
  logic [IW-1:0]           index_reg, index_next;
  logic [PW-1:0]           presc_reg, presc_next;
  logic [GW-1:0]           guard_reg, guard_next;
  logic [4*NUM_DIGITS-1:0] shadow_digits_reg;
  logic [NUM_DIGITS-1:0]   shadow_dp_reg;
  logic [6:0]              seg_reg, seg_next;
  logic                    dp_reg, dp_next;
  logic [NUM_DIGITS-1:0]   an_reg, an_next;
  logic                    tick_reg, tick_next;

  logic [3:0]              digit_arr [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   blank_vec;
  logic [IW-1:0]           entry_idx;
  logic [6:0]              entry_seg;
  logic                    entry_dp;
  logic [NUM_DIGITS-1:0]   entry_an;

  // A digit is blank when it and every more-significant digit are zero
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign digit_arr[gi] = shadow_digits_reg[4*gi +: 4];
    if (gi == 0 || BLANK_LZ == 0) begin : g_keep
      assign blank_vec[gi] = 1'b0;
    end else begin : g_lz
      assign blank_vec[gi] = (shadow_digits_reg[4*NUM_DIGITS-1:4*gi] == '0);
    end
  end

  // Digit about to enter DRIVE: 0 when leaving OFF, otherwise the successor
  assign entry_idx = (state_reg == GUARD && index_reg != INDEX_LAST) ? index_reg + 1'b1 : '0;
  assign entry_dp  = ~shadow_dp_reg[entry_idx];
  assign entry_an  = ~(NUM_DIGITS'(1) << entry_idx);

  bcd_to_seg7 u_decode (
    .bcd   (digit_arr[entry_idx]),
    .blank (blank_vec[entry_idx]),
    .seg_n (entry_seg)
  );

  always_comb begin
    state_next = state_reg;
    index_next = index_reg;
    presc_next = presc_reg;
    guard_next = guard_reg;
    seg_next   = seg_reg;
    dp_next    = dp_reg;
    an_next    = an_reg;
    tick_next  = 1'b0;
    if (!enable) begin
      state_next = OFF;
      index_next = '0;
      presc_next = '0;
      guard_next = '0;
      seg_next   = SEG_BLANK;
      dp_next    = 1'b1;
      an_next    = AN_OFF;
    end else begin
      case (state_reg)
        OFF: begin
          state_next = DRIVE;
          index_next = entry_idx;
          presc_next = '0;
          an_next    = entry_an;
          seg_next   = entry_seg;
          dp_next    = entry_dp;
        end
        DRIVE: begin
          if (presc_reg == PRESC_LAST) begin
            state_next = GUARD;
            presc_next = '0;
            guard_next = '0;
            an_next    = AN_OFF;
            seg_next   = SEG_BLANK;
            dp_next    = 1'b1;
            tick_next  = (index_reg == INDEX_LAST);
          end else begin
            presc_next = presc_reg + 1'b1;
          end
        end
        GUARD: begin
          if (guard_reg == GUARD_LAST) begin
            state_next = DRIVE;
            index_next = entry_idx;
            presc_next = '0;
            guard_next = '0;
            an_next    = entry_an;
            seg_next   = entry_seg;
            dp_next    = entry_dp;
          end else begin
            guard_next = guard_reg + 1'b1;
          end
        end
        default: state_next = OFF;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= OFF;
      index_reg <= '0;
      presc_reg <= '0;
      guard_reg <= '0;
      seg_reg   <= SEG_BLANK;
      dp_reg    <= 1'b1;
      an_reg    <= AN_OFF;
      tick_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      index_reg <= index_next;
      presc_reg <= presc_next;
      guard_reg <= guard_next;
      seg_reg   <= seg_next;
      dp_reg    <= dp_next;
      an_reg    <= an_next;
      tick_reg  <= tick_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_digits_reg <= '0;
      shadow_dp_reg     <= '0;
    end else if (load) begin
      shadow_digits_reg <= digits_in;
      shadow_dp_reg     <= dp_in;
    end
  end

  assign seg_n     = seg_reg;
  assign dp_n      = dp_reg;
  assign an_n      = an_reg;
  assign scan_tick = tick_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a scan-position reference model queues the
// expected pins for every cycle and an independent monitor pops and compares them.
module tb_seg7_scan_driver;

  localparam int N   = 4;
  localparam int RD  = 4;
  localparam int GC  = 1;
  localparam int BLZ = 1;
  localparam int P   = RD + GC;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           enable = 1'b0;
  logic           load = 1'b0;
  logic [4*N-1:0] digits_in = '0;
  logic [N-1:0]   dp_in = '0;
  logic [6:0]     seg_n;
  logic           dp_n;
  logic [N-1:0]   an_n;
  logic           scan_tick;
  bit             clk_run = 1'b0;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [N-1:0] an;
    logic [6:0]   seg;
    logic         dp;
    logic         tick;
  } exp_t;

  exp_t exp_q[$];
  logic [6:0] seg_table [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  seg7_scan_driver #(
    .NUM_DIGITS   (N),
    .REFRESH_DIV  (RD),
    .GUARD_CYCLES (GC),
    .BLANK_LZ     (BLZ)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .load      (load),
    .digits_in (digits_in),
    .dp_in     (dp_in),
    .seg_n     (seg_n),
    .dp_n      (dp_n),
    .an_n      (an_n),
    .scan_tick (scan_tick)
  );

  initial forever begin
    #5;
    if (clk_run) clk = ~clk;
  end

  function automatic logic [6:0] ref_decode(input logic [4*N-1:0] v, input int k);
    logic [4*N-1:0] sh;
    int val;
    sh  = v >> (4*k);
    val = int'(sh[3:0]);
    if (BLZ != 0 && k > 0 && sh == '0) return 7'h7F;
    if (val > 9) return 7'h7F;
    return ~seg_table[val];
  endfunction

  task automatic check_out(input string name, input exp_t e);
    checks++;
    if (an_n !== e.an || seg_n !== e.seg || dp_n !== e.dp || scan_tick !== e.tick) begin
      failures++;
      $display("FAIL %s t=%0t got an=%b seg=%h dp=%b tick=%b required an=%b seg=%h dp=%b tick=%b",
               name, $time, an_n, seg_n, dp_n, scan_tick, e.an, e.seg, e.dp, e.tick);
    end
  endtask

  // Reference model: position within the scan period decides digit and phase
  initial begin
    exp_t e;
    int m_pos, d, ph;
    bit m_active;
    logic [4*N-1:0] m_digits;
    logic [N-1:0] m_dp;
    logic [6:0] m_seg;
    logic m_dpl;
    m_active = 0; m_pos = 0; m_digits = '0; m_dp = '0; m_seg = 7'h7F; m_dpl = 1'b1;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        exp_q.delete();
        m_active = 0; m_pos = 0; m_digits = '0; m_dp = '0;
      end else begin
        e.an = '1; e.seg = 7'h7F; e.dp = 1'b1; e.tick = 1'b0;
        if (!enable) begin
          m_active = 0;
        end else begin
          if (!m_active) begin
            m_active = 1;
            m_pos = 0;
          end else begin
            m_pos = (m_pos + 1) % (N*P);
          end
          d  = m_pos / P;
          ph = m_pos % P;
          if (ph == 0) begin
            m_seg = ref_decode(m_digits, d);
            m_dpl = ~m_dp[d];
          end
          if (ph < RD) begin
            e.an  = ~(N'(1) << d);
            e.seg = m_seg;
            e.dp  = m_dpl;
          end
          e.tick = (d == N-1 && ph == RD);
        end
        if (load) begin
          m_digits = digits_in;
          m_dp = dp_in;
        end
        exp_q.push_back(e);
      end
    end
  end

  // Monitor: compares pins one step after each active edge
  initial begin
    exp_t e, r;
    r.an = '1; r.seg = 7'h7F; r.dp = 1'b1; r.tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        check_out("reset_hold", r);
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_out("scoreboard", e);
      end else begin
        checks++;
        failures++;
        $display("FAIL scoreboard_empty t=%0t got no expected entry required one", $time);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [4*N-1:0] d, input logic [N-1:0] p);
    @(negedge clk);
    digits_in = d;
    dp_in = p;
    load = 1'b1;
    $display("LOAD digits=%h dp=%b t=%0t", d, p, $time);
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_for_an(input logic [N-1:0] target, input string name);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (an_n === target) return;
    end
    checks++;
    failures++;
    $display("FAIL %s timeout got an=%b required an=%b", name, an_n, target);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got no finish required finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t r;
    r.an = '1; r.seg = 7'h7F; r.dp = 1'b1; r.tick = 1'b0;

    // Reset with the clock stopped
    #2 reset = 1'b1;
    #1 check_out("reset_no_clock", r);
    clk_run = 1'b1;
    cycles(3);
    reset = 1'b0;
    $display("RESET released t=%0t", $time);

    do_load(16'h1234, 4'b0000);
    @(negedge clk) enable = 1'b1;
    $display("ENABLE on t=%0t", $time);
    cycles(45);

    do_load(16'h0070, 4'b0000);
    cycles(25);
    do_load(16'h0000, 4'b0000);
    cycles(25);
    do_load(16'h5678, 4'b1010);
    cycles(22);

    // Load in the middle of digit 1's drive period
    wait_for_an(4'b1101, "wait_digit1");
    do_load(16'h9999, 4'b0100);
    cycles(25);

    do_load(16'h000A, 4'b0001);
    cycles(25);

    // Drop enable during a guard cycle, re-raise after three cycles
    wait_for_an(4'b1111, "wait_guard");
    enable = 1'b0;
    $display("ENABLE off in guard t=%0t", $time);
    cycles(3);
    enable = 1'b1;
    $display("ENABLE on t=%0t", $time);
    cycles(25);

    // Randomized loads and enable toggles
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      load = ($urandom_range(0, 7) == 0);
      if (load) begin
        for (int k = 0; k < N; k++)
          digits_in[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 11)) : 4'd0;
        dp_in = N'($urandom);
        $display("LOAD digits=%h dp=%b t=%0t", digits_in, dp_in, $time);
      end
      if (enable && $urandom_range(0, 39) == 0) begin
        enable = 1'b0;
        $display("ENABLE off t=%0t", $time);
      end else if (!enable && $urandom_range(0, 3) == 0) begin
        enable = 1'b1;
        $display("ENABLE on t=%0t", $time);
      end
    end
    @(negedge clk);
    load = 1'b0;
    enable = 1'b1;
    do_load(16'h4321, 4'b1000);
    cycles(10);

    // Asynchronous reset in the middle of a drive period
    wait_for_an(4'b1011, "wait_digit2");
    @(posedge clk);
    #2 reset = 1'b1;
    $display("RESET asserted mid-drive t=%0t", $time);
    #1 check_out("reset_mid_drive", r);
    @(negedge clk);
    reset = 1'b0;
    $display("RESET released t=%0t", $time);
    cycles(25);
    do_load(16'h0502, 4'b0010);
    cycles(25);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
